// File: rtl/bcd_digit_source_if.sv
// Signal bundle between the BCD digit source and whatever drives or observes it.
// The master drives the control inputs; the slave (the digit source) returns the digit and pulses.
interface bcd_digit_source_if;
  logic       en;
  logic       auto;
  logic       up_dn;
  logic       btn;
  logic       load;
  logic [3:0] load_val;
  logic       a0;
  logic       a1;
  logic       a2;
  logic       a3;
  logic       tick_out;
  logic       carry;
  logic       borrow;
  logic       load_err;

  modport master (
    output en, auto, up_dn, btn, load, load_val,
    input  a0, a1, a2, a3, tick_out, carry, borrow, load_err
  );

  modport slave (
    input  en, auto, up_dn, btn, load, load_val,
    output a0, a1, a2, a3, tick_out, carry, borrow, load_err
  );
endinterface

// File: rtl/bcd_digit_source.sv
// Single decimal digit (0-9) feeding a BCD decoder; steps on a prescaled tick or a
// debounced button press, with parallel load and carry/borrow pulses for cascading.
module bcd_digit_source #(
  parameter int TICK_DIV   = 50_000_000,
  parameter int DEB_CYCLES = 500_000
) (
  input  logic               clk,
  input  logic               rst,
  bcd_digit_source_if.slave  bus
);
  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CYCLES - 1);

  logic [PW-1:0] r_presc;
  logic          r_s1;
  logic          r_s2;
  logic          r_level;
  logic          r_level_d;
  logic [DW-1:0] r_deb_cnt;
  logic [3:0]    r_digit;
  logic          r_tick;
  logic          r_carry;
  logic          r_borrow;
  logic          r_load_err;

  logic          w_run;
  logic          w_auto_req;
  logic          w_man_req;
  logic          w_step;
  logic [3:0]    w_digit_next;
  logic          w_carry_next;
  logic          w_borrow_next;
  logic          w_load_err_next;

  assign w_run      = bus.en & bus.auto;
  assign w_auto_req = w_run & (r_presc == PRESC_LAST);
  // A manual request is the edge right after the debounced level rose.
  assign w_man_req  = r_level & ~r_level_d;
  assign w_step     = bus.en & (w_auto_req | (w_man_req & ~bus.auto));

  always_comb begin
    w_digit_next    = r_digit;
    w_carry_next    = 1'b0;
    w_borrow_next   = 1'b0;
    w_load_err_next = 1'b0;
    if (bus.load) begin
      if (bus.load_val <= 4'd9) begin
        w_digit_next = bus.load_val;
      end else begin
        w_load_err_next = 1'b1;
      end
    end else if (w_step) begin
      if (bus.up_dn) begin
        if (r_digit == 4'd9) begin
          w_digit_next = 4'd0;
          w_carry_next = 1'b1;
        end else begin
          w_digit_next = r_digit + 4'd1;
        end
      end else begin
        if (r_digit == 4'd0) begin
          w_digit_next  = 4'd9;
          w_borrow_next = 1'b1;
        end else begin
          w_digit_next = r_digit - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc    <= '0;
      r_s1       <= 1'b0;
      r_s2       <= 1'b0;
      r_level    <= 1'b0;
      r_level_d  <= 1'b0;
      r_deb_cnt  <= '0;
      r_digit    <= 4'd0;
      r_tick     <= 1'b0;
      r_carry    <= 1'b0;
      r_borrow   <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      if (!w_run || r_presc == PRESC_LAST) begin
        r_presc <= '0;
      end else begin
        r_presc <= r_presc + PW'(1);
      end

      r_s1      <= bus.btn;
      r_s2      <= r_s1;
      r_level_d <= r_level;
      // Level flips only after DEB_CYCLES consecutive disagreeing samples.
      if (r_s2 == r_level) begin
        r_deb_cnt <= '0;
      end else if (r_deb_cnt == DEB_LAST) begin
        r_level   <= ~r_level;
        r_deb_cnt <= '0;
      end else begin
        r_deb_cnt <= r_deb_cnt + DW'(1);
      end

      r_digit    <= w_digit_next;
      r_tick     <= w_auto_req;
      r_carry    <= w_carry_next;
      r_borrow   <= w_borrow_next;
      r_load_err <= w_load_err_next;
    end
  end

  assign bus.a0       = r_digit[0];
  assign bus.a1       = r_digit[1];
  assign bus.a2       = r_digit[2];
  assign bus.a3       = r_digit[3];
  assign bus.tick_out = r_tick;
  assign bus.carry    = r_carry;
  assign bus.borrow   = r_borrow;
  assign bus.load_err = r_load_err;
endmodule

// File: tb/tb_bcd_digit_source.sv
// Scoreboard bench for bcd_digit_source: a reference model pushes the expected
// post-edge outputs for every driven cycle; a monitor pops and compares after each edge.
module tb_bcd_digit_source;
  localparam int TICK_DIV   = 4;
  localparam int DEB_CYCLES = 3;

  typedef struct packed {
    logic [3:0] d;
    logic       t;
    logic       c;
    logic       b;
    logic       e;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  bcd_digit_source_if bus_if();

  bcd_digit_source #(.TICK_DIV(TICK_DIV), .DEB_CYCLES(DEB_CYCLES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  // Reference model state, phrased in terms of observable behaviour.
  int   m_digit = 0;
  int   m_run   = 0;
  bit   m_level = 0;
  bit   m_rose  = 0;
  bit   raw_hist[$];
  bit   s2_hist[$];

  function automatic void chk(string name, int act, int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cycle, act, expv);
    end
  endfunction

  task automatic model_edge();
    exp_t e;
    bit   s2;
    bit   tick;
    bit   mreq;
    bit   flip;
    bit   step;
    e = '0;
    if (rst) begin
      m_digit = 0;
      m_run   = 0;
      m_level = 0;
      m_rose  = 0;
      raw_hist.delete();
      s2_hist.delete();
    end else begin
      // Tick every TICK_DIV-th consecutive enabled auto cycle.
      if (bus_if.en && bus_if.auto) m_run++;
      else m_run = 0;
      tick = bus_if.en && bus_if.auto && (m_run % TICK_DIV == 0);
      // Button seen through a two-cycle synchronizer delay.
      s2 = (raw_hist.size() >= 2) ? raw_hist[raw_hist.size()-2] : 1'b0;
      raw_hist.push_back(bus_if.btn);
      if (raw_hist.size() > 2) void'(raw_hist.pop_front());
      s2_hist.push_back(s2);
      if (s2_hist.size() > DEB_CYCLES) void'(s2_hist.pop_front());
      flip = (s2_hist.size() == DEB_CYCLES);
      foreach (s2_hist[i]) if (s2_hist[i] == m_level) flip = 0;
      mreq   = m_rose;
      m_rose = flip && !m_level;
      if (flip) begin
        m_level = !m_level;
        s2_hist.delete();
      end
      step = bus_if.en && (tick || (mreq && !bus_if.auto));
      if (bus_if.load) begin
        if (bus_if.load_val <= 9) m_digit = int'(bus_if.load_val);
        else e.e = 1'b1;
      end else if (step) begin
        if (bus_if.up_dn) begin
          if (m_digit == 9) e.c = 1'b1;
          m_digit = (m_digit + 1) % 10;
        end else begin
          if (m_digit == 0) e.b = 1'b1;
          m_digit = (m_digit + 9) % 10;
        end
      end
      e.t = tick;
    end
    e.d = 4'(m_digit);
    exp_q.push_back(e);
  endtask

  task automatic cyc();
    model_edge();
    @(posedge clk);
    #2;
    cycle++;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("digit",    int'({bus_if.a3, bus_if.a2, bus_if.a1, bus_if.a0}), int'(mon_e.d));
      chk("tick_out", int'(bus_if.tick_out), int'(mon_e.t));
      chk("carry",    int'(bus_if.carry),    int'(mon_e.c));
      chk("borrow",   int'(bus_if.borrow),   int'(mon_e.b));
      chk("load_err", int'(bus_if.load_err), int'(mon_e.e));
      $display("cycle %0d: digit=%0d tick=%0b carry=%0b borrow=%0b load_err=%0b", cycle,
               {bus_if.a3, bus_if.a2, bus_if.a1, bus_if.a0}, bus_if.tick_out,
               bus_if.carry, bus_if.borrow, bus_if.load_err);
    end
  end

  initial begin
    int btn_left;
    rst = 1'b1;
    bus_if.en = 0; bus_if.auto = 0; bus_if.up_dn = 1; bus_if.btn = 0;
    bus_if.load = 0; bus_if.load_val = 4'd0;
    cycles(2);
    rst = 1'b0;

    // Auto count up through a wrap.
    bus_if.en = 1; bus_if.auto = 1; bus_if.up_dn = 1;
    cycles(44);

    // Count down from 0 through a borrow.
    bus_if.load = 1; bus_if.load_val = 4'd0; cyc();
    bus_if.load = 0; bus_if.up_dn = 0;
    cycles(14);

    // Valid load, rejected load.
    bus_if.load = 1; bus_if.load_val = 4'd7; cyc();
    bus_if.load_val = 4'd12; cyc();
    bus_if.load = 0; cyc();

    // Load coinciding with a tick while the digit is 9: no carry.
    bus_if.up_dn = 1;
    bus_if.load = 1; bus_if.load_val = 4'd9; cyc();
    bus_if.load = 0;
    while ((m_run + 1) % TICK_DIV != 0) cyc();
    bus_if.load = 1; bus_if.load_val = 4'd3; cyc();
    bus_if.load = 0; cycles(3);

    // Manual mode: bounce, then a long press, then release.
    bus_if.auto = 0;
    for (int i = 0; i < 10; i++) begin
      bus_if.btn = (i % 2 == 0);
      cyc();
    end
    bus_if.btn = 0; cycles(6);
    bus_if.btn = 1; cycles(20);
    bus_if.btn = 0; cycles(10);

    // Reset while a carry is about to happen.
    bus_if.auto = 1;
    bus_if.load = 1; bus_if.load_val = 4'd9; cyc();
    bus_if.load = 0;
    while ((m_run + 1) % TICK_DIV != 0) cyc();
    rst = 1; cyc();
    rst = 0; cycles(9);

    // Disable mid-prescale, then re-enable.
    cycles(2);
    bus_if.en = 0; cycles(10);
    bus_if.en = 1; cycles(9);

    // Randomized mix of every input.
    btn_left = 0;
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      bus_if.en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 29) == 0) bus_if.auto = ~bus_if.auto;
      if ($urandom_range(0, 15) == 0) bus_if.up_dn = ~bus_if.up_dn;
      bus_if.load = ($urandom_range(0, 19) == 0);
      bus_if.load_val = 4'($urandom_range(0, 15));
      if (btn_left == 0) begin
        bus_if.btn = ~bus_if.btn;
        btn_left = $urandom_range(1, 8);
      end
      btn_left--;
      cyc();
    end
    rst = 0; bus_if.load = 0;
    cycles(2);

    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
